// File: rtl/de_fb_pkg.sv
// Shared types and widths for the drawing-engine framebuffer responder.
// Imported by the arbiter and the responder top.
package de_fb_pkg;

  localparam int DE_ADDR_W = 18;
  localparam int DE_DATA_W = 32;
  localparam int DE_LANES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    DE_CAP,
    DE_ACK,
    VID_CAP,
    VID_ACK
  } state_e;

endpackage

// File: rtl/de_fb_arbiter.sv
// Video/drawing-engine grant logic with a starvation counter
// that bounds how many video grants may pass a pending de request.
module de_fb_arbiter
  import de_fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic de_req_i,
  input  logic vid_req_i,
  output logic gnt_de_o,
  output logic gnt_vid_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Video wins unless de has already been passed over LIM times.
  always_comb begin
    gnt_vid_o = en_i && vid_req_i && (!de_req_i || (cnt_q < LIM));
    gnt_de_o  = en_i && de_req_i && !gnt_vid_o;
  end

  // Count video grants that overtake a waiting de request.
  always_comb begin
    cnt_d = cnt_q;
    if (!de_req_i || gnt_de_o) begin
      cnt_d = '0;
    end else if (gnt_vid_o && (cnt_q < LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/de_fb_responder.sv
// Framebuffer SRAM responder serving a drawing-engine port and a
// video scan-out port. The SRAM command is issued from IDLE.
module de_fb_responder
  import de_fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de_req,
  output logic                 de_ack,
  input  logic [DE_ADDR_W-1:0] de_addr,
  input  logic [DE_LANES-1:0]  de_nbyte,
  input  logic                 de_rnw,
  input  logic [DE_DATA_W-1:0] de_w_data,
  output logic [DE_DATA_W-1:0] de_r_data,
  input  logic                 vid_req,
  input  logic [DE_ADDR_W-1:0] vid_addr,
  output logic                 vid_ack,
  output logic [DE_DATA_W-1:0] vid_data,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [DE_LANES-1:0]  mem_be,
  output logic [DE_ADDR_W-1:0] mem_addr,
  output logic [DE_DATA_W-1:0] mem_wdata,
  input  logic [DE_DATA_W-1:0] mem_rdata
);

  state_e               state_q;
  logic                 de_ack_q;
  logic                 vid_ack_q;
  logic [DE_DATA_W-1:0] de_r_data_q;
  logic [DE_DATA_W-1:0] vid_data_q;
  logic                 arb_en;
  logic                 gnt_de;
  logic                 gnt_vid;

  assign arb_en = (state_q == IDLE) && !rst;

  de_fb_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .de_req_i (de_req),
    .vid_req_i(vid_req),
    .gnt_de_o (gnt_de),
    .gnt_vid_o(gnt_vid)
  );

  // SRAM command: only driven in the grant cycle, zero otherwise.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vid) begin
      mem_cs   = 1'b1;
      mem_be   = '1;
      mem_addr = vid_addr;
    end else if (gnt_de) begin
      mem_addr = de_addr;
      if (de_rnw) begin
        mem_cs = 1'b1;
        mem_be = '1;
      end else begin
        mem_cs    = (de_nbyte != '1);
        mem_we    = 1'b1;
        mem_be    = ~de_nbyte;
        mem_wdata = de_w_data;
      end
    end
  end

  // Access sequencer: capture read data, pulse acks, back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      de_ack_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
      de_r_data_q <= '0;
      vid_data_q  <= '0;
    end else begin
      de_ack_q  <= 1'b0;
      vid_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vid) begin
            state_q <= VID_CAP;
          end else if (gnt_de) begin
            if (de_rnw) begin
              state_q <= DE_CAP;
            end else begin
              state_q  <= DE_ACK;
              de_ack_q <= 1'b1;
            end
          end
        end
        DE_CAP: begin
          de_r_data_q <= mem_rdata;
          de_ack_q    <= 1'b1;
          state_q     <= DE_ACK;
        end
        DE_ACK: begin
          state_q <= IDLE;
        end
        VID_CAP: begin
          vid_data_q <= mem_rdata;
          vid_ack_q  <= 1'b1;
          state_q    <= VID_ACK;
        end
        VID_ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign de_ack    = de_ack_q;
  assign vid_ack   = vid_ack_q;
  assign de_r_data = de_r_data_q;
  assign vid_data  = vid_data_q;

endmodule
